mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified memory between the fetch stage (instruction reads) and the memory stage (read, write, push, pop). It sequences each access through a fixed-latency memory, stalls the losing requester, and owns the stack pointer used by push/pop. It sits between `fetch_stage`/`memory_stage` and the memory macro.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 1, memory read latency in cycles (≥1): `mem_rdata` is valid `MEM_LAT` cycles after the `mem_en` cycle
- `SP_INIT`, 16'hFFFF, stack pointer reset value

Ports:
- `clk` in 1: clock; the block uses one clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request, held until `if_valid`
- `if_addr` in ADDR_W: fetch address
- `if_rdata` out DATA_W: fetched word, registered
- `if_valid` out 1: one-cycle fetch completion
- `if_stall` out 1: `if_req & ~if_valid`
- `dm_read`, `dm_write`, `dm_push`, `dm_pop` in 1 each: data ops, held until `dm_valid`
- `dm_addr` in ADDR_W: read/write address; ignored for push/pop
- `dm_wdata` in DATA_W: write/push data
- `dm_rdata` out DATA_W: read/pop data, registered
- `dm_valid` out 1: one-cycle data completion, also the write ack
- `dm_stall` out 1: `dm_any & ~dm_valid`
- `mem_en`, `mem_we` out 1: memory strobe and write enable
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory request
- `mem_rdata` in DATA_W: memory read data
- `sp` out ADDR_W: current stack pointer

## Operation
- FSM with three states: IDLE, BUSY, DONE.
- **IDLE**
  - If there is a request, issue it: drive `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` combinationally this cycle, then go to BUSY.
  - Record the owner: IF or DM.
  - Clear the latency counter.
- **BUSY**
  - Count up to `MEM_LAT`.
  - In the cycle the count equals `MEM_LAT`, capture `mem_rdata` into the owner's rdata register (reads and pops only), then go to DONE.
- **DONE**
  - Assert the owner's valid for one cycle; issue nothing; go to IDLE.
  - Because nothing issues in DONE, a request still asserted in its valid cycle is not reissued.
- **Arbitration**
  - DM wins over IF by default.
  - If the last completed access was DM and `if_req` is pending, IF wins the next issue. DM and IF therefore alternate under contention, and there is no starvation.
- **Illegal multiple DM ops:** priority push > pop > write > read.
- **Stack** (push/pop handling requires `STACK_EN`; see Configuration)
  - Push: write `mem[sp]`, then `sp ← sp−1`.
  - Pop: read `mem[sp+1]` and `sp ← sp+1`.
  - `sp` updates at the issue edge.
  - Arithmetic is modulo 2^ADDR_W: 0−1 wraps to all-ones, all-ones+1 wraps to 0. No overflow flag.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0 outside the issue cycle.

## Timing
- Issue in cycle 0; valid in cycle `MEM_LAT`+1; next issue at the earliest in cycle `MEM_LAT`+2.
- Stalls are combinational and deassert in the valid cycle, so the pipeline advances at that cycle's closing edge.
- Reset values: state IDLE; `if_valid`, `dm_valid`, `if_rdata`, `dm_rdata`, `mem_*` and the counter all 0; `sp` = `SP_INIT`; last-grant = IF.
- Stalls follow their equations during reset, so they equal their requests.
- **Reset mid-access:** abort immediately; the in-flight response is discarded; no valid is produced; the `sp` update is undone only by reload to `SP_INIT`.

## Configuration
- `MEM_ARB_STACK_EN` defined:
  - Push/pop are arbitrated as described.
  - The SP register is present.
- `MEM_ARB_STACK_EN` undefined:
  - Push/pop are ignored and never issue or produce `dm_valid`.
  - `dm_any` covers only read/write, so push/pop do not stall.
  - `sp` is tied to `SP_INIT`.
  - The SP logic is removed.

## Structure
- Shared package `proc_pkg`:
  - state enum `arb_state_t` (IDLE/BUSY/DONE)
  - owner enum `arb_owner_t` (IF/DM)
  - DM op encoding `dm_op_t` (NONE/READ/WRITE/PUSH/POP)
- One sub-module, `stack_pointer`: register plus inc/dec, compiled only under `MEM_ARB_STACK_EN`.

## Test plan
- **Reset:** hold `rst`=0 with `if_req`=1 → `sp`=0xFFFF, valids 0, `mem_en`=0, `if_stall`=1; release → issue in the next cycle.
- **Fetch, MEM_LAT=1:**
  - Stimulus: `if_addr`=0x0010, memory returns 0xABCD.
  - Response: `mem_en` in cycle 0; `if_valid` in cycle 2 with `if_rdata`=0xABCD; `if_stall` high in cycles 0–1.
- **Contention:**
  - Stimulus: `if_req` and `dm_read`@0x0200 both rise in cycle 0.
  - Response: DM issues in cycle 0 and `dm_valid` rises in cycle 2; IF issues in cycle 3 and `if_valid` rises in cycle 5.
- **Alternation:**
  - Stimulus: `dm_write` re-asserted every cycle after each ack, `if_req` held.
  - Response: issue order is DM, IF, DM, IF.
- **Stack:**
  - Push 0x1234 at `sp`=0xFFFF → write to 0xFFFF, `sp`=0xFFFE.
  - Pop → read from 0xFFFF, `dm_rdata`=0x1234, `sp`=0xFFFF.
  - Push at `sp`=0x0000 → `sp`=0xFFFF.
  - Without the macro: push gives no `mem_en` and `dm_stall`=0.
- **Reset mid-op:**
  - Stimulus: `rst` low in the BUSY cycle of a pop.
  - Response: no `dm_valid`; `sp`=`SP_INIT`; a request held across reset release is reissued cleanly.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, access owner and
// decoded data-stage operation, plus the DM op priority decoder.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } dm_op_t;

  // Several strobes at once is illegal upstream; resolve push > pop > write > read.
  function automatic dm_op_t dm_op_decode(input logic rd, input logic wr,
                                          input logic push, input logic pop);
    if (push)      return OP_PUSH;
    else if (pop)  return OP_POP;
    else if (wr)   return OP_WRITE;
    else if (rd)   return OP_READ;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data-stage, memory-macro and stack-pointer signals around
// mem_arbiter. slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_read;
  logic              dm_write;
  logic              dm_push;
  logic              dm_pop;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [ADDR_W-1:0] sp;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_push, dm_pop, dm_addr, dm_wdata,
           mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, sp
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_push, dm_pop, dm_addr, dm_wdata,
           mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, sp
  );
endinterface

// File: rtl/mem_arbiter_stack_pointer.sv
// Stack pointer register for push/pop; present only when MEM_ARB_STACK_EN is
// defined. Moves at the issue edge, wrapping modulo 2^ADDR_W.
`ifdef MEM_ARB_STACK_EN
module stack_pointer #(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp
);

  logic [ADDR_W-1:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q - ADDR_W'(1);
    else if (pop) sp_d = sp_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sp_q <= SP_INIT;
    else      sp_q <= sp_d;
  end

  assign sp = sp_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data stages; IDLE/BUSY/DONE per
// access. Push/pop and the stack pointer exist only with MEM_ARB_STACK_EN.
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter int                MEM_LAT = 1,
  parameter logic [ADDR_W-1:0] SP_INIT = 16'hFFFF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int             CNT_W = $clog2(MEM_LAT + 1) + 1;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  dm_op_t            op_q, op_d;
  logic              last_dm_q, last_dm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;

  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              push_req, pop_req, sp_push, sp_pop;
  logic [ADDR_W-1:0] sp;
  dm_op_t            dm_op;
  logic              dm_any, grant_dm, grant_if, issue, cnt_hit;

`ifdef MEM_ARB_STACK_EN
  assign push_req = bus.dm_push;
  assign pop_req  = bus.dm_pop;

  stack_pointer #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
    .clk  (clk),
    .rst  (rst),
    .push (sp_push),
    .pop  (sp_pop),
    .sp   (sp)
  );
`else
  logic unused_stack;
  assign unused_stack = bus.dm_push | bus.dm_pop | sp_push | sp_pop;
  assign push_req     = 1'b0;
  assign pop_req      = 1'b0;
  assign sp           = SP_INIT;
`endif

  assign dm_op    = dm_op_decode(bus.dm_read, bus.dm_write, push_req, pop_req);
  assign dm_any   = (dm_op != OP_NONE);
  // After a DM completion a waiting fetch goes first, so neither side starves.
  assign grant_dm = dm_any & ~(last_dm_q & bus.if_req);
  assign grant_if = bus.if_req & ~grant_dm;
  assign issue    = rst & (state_q == ST_IDLE) & (grant_dm | grant_if);
  assign cnt_hit  = (cnt_q + CNT_W'(1)) == LAT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue)   state_d = ST_BUSY;
      ST_BUSY: if (cnt_hit) state_d = ST_DONE;
      ST_DONE:              state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    sp_push    = 1'b0;
    sp_pop     = 1'b0;
    owner_d    = owner_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    last_dm_d  = last_dm_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          mem_en = 1'b1;
          cnt_d  = '0;
          if (grant_dm) begin
            owner_d = OWN_DM;
            op_d    = dm_op;
            case (dm_op)
              OP_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = bus.dm_addr;
                mem_wdata = bus.dm_wdata;
              end
              OP_PUSH: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = bus.dm_wdata;
                sp_push   = 1'b1;
              end
              OP_POP: begin
                mem_addr = sp + ADDR_W'(1);
                sp_pop   = 1'b1;
              end
              default: mem_addr = bus.dm_addr;
            endcase
          end else begin
            owner_d  = OWN_IF;
            op_d     = OP_NONE;
            mem_addr = bus.if_addr;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_hit) begin
          if (owner_q == OWN_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_valid_d = 1'b1;
            if (op_q == OP_READ || op_q == OP_POP) dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      ST_DONE: last_dm_d = (owner_q == OWN_DM);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_IF;
      op_q       <= OP_NONE;
      last_dm_q  <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      op_q       <= op_d;
      last_dm_q  <= last_dm_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_stall  = dm_any & ~dm_valid_q;
  assign bus.sp        = sp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing cases followed by randomized traffic
// scored against a transaction-level schedule and shadow memory.
module tb_mem_arbiter;

  localparam int MEM_LAT = 1;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .SP_INIT(16'hFFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hBBCD;
  endfunction

  // Memory macro: data valid MEM_LAT (=1) cycle after the strobe, noise otherwise.
  logic [15:0] mac_mem [0:65535];
  bit          mac_init;
  always @(posedge clk) begin
    if (!mac_init) begin
      for (int i = 0; i < 65536; i++) mac_mem[i] <= init_val(16'(i));
      mac_init <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      mac_mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (mac_init && bus.mem_en && !bus.mem_we) bus.mem_rdata <= mac_mem[bus.mem_addr];
    else                                       bus.mem_rdata <= 16'($urandom);
  end

  logic [15:0] ref_mem [0:65535];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr_dm();
    bus.dm_read  = 1'b0;
    bus.dm_write = 1'b0;
    bus.dm_push  = 1'b0;
    bus.dm_pop   = 1'b0;
  endtask

  int          n_iss, n_done, free_at, vc, if_vc, dm_vc;
  bit          iss_we [4];
  bit          pend_chg, if_busy, dm_busy, last_dm, own_dm, exp_en, exp_we, exp_rdc;
  logic [3:0]  flg;
  logic [15:0] msp, sp_now, exp_addr, exp_wd, exp_rd;

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    rst = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    clr_dm();
    repeat (3) @(posedge clk);
    mid();
    chk("rst_sp", bus.sp, 16'hFFFF);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_dm_valid", bus.dm_valid, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_if_stall", bus.if_stall, 1);
    chk("rst_dm_stall", bus.dm_stall, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);

    // Fetch after release: issue at cycle 0, valid at cycle 2.
    adv(); rst = 1'b1;
    mid();
    chk("fe_c0_en", bus.mem_en, 1);
    chk("fe_c0_addr", bus.mem_addr, 16'h0010);
    chk("fe_c0_we", bus.mem_we, 0);
    chk("fe_c0_stall", bus.if_stall, 1);
    adv(); mid();
    chk("fe_c1_en", bus.mem_en, 0);
    chk("fe_c1_valid", bus.if_valid, 0);
    chk("fe_c1_stall", bus.if_stall, 1);
    adv(); mid();
    chk("fe_c2_valid", bus.if_valid, 1);
    chk("fe_c2_rdata", bus.if_rdata, 16'hABCD);
    chk("fe_c2_stall", bus.if_stall, 0);
    chk("fe_c2_en", bus.mem_en, 0);
    adv(); bus.if_req = 1'b0;
    mid();
    chk("fe_c3_en", bus.mem_en, 0);
    chk("fe_c3_valid", bus.if_valid, 0);

    // Contention: DM first, IF three cycles later.
    adv();
    bus.if_req = 1'b1; bus.if_addr = 16'h0300;
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0200;
    mid();
    chk("ct_c0_en", bus.mem_en, 1);
    chk("ct_c0_addr", bus.mem_addr, 16'h0200);
    chk("ct_c0_dm_stall", bus.dm_stall, 1);
    chk("ct_c0_if_stall", bus.if_stall, 1);
    adv(); mid();
    chk("ct_c1_en", bus.mem_en, 0);
    adv(); mid();
    chk("ct_c2_dm_valid", bus.dm_valid, 1);
    chk("ct_c2_dm_rdata", bus.dm_rdata, init_val(16'h0200));
    chk("ct_c2_if_valid", bus.if_valid, 0);
    chk("ct_c2_dm_stall", bus.dm_stall, 0);
    chk("ct_c2_en", bus.mem_en, 0);
    adv(); bus.dm_read = 1'b0;
    mid();
    chk("ct_c3_en", bus.mem_en, 1);
    chk("ct_c3_addr", bus.mem_addr, 16'h0300);
    adv(); adv(); mid();
    chk("ct_c5_if_valid", bus.if_valid, 1);
    chk("ct_c5_if_rdata", bus.if_rdata, init_val(16'h0300));
    adv(); bus.if_req = 1'b0;

    // Alternation under sustained contention.
    adv();
    bus.if_req = 1'b1; bus.if_addr = 16'h0310;
    bus.dm_write = 1'b1; bus.dm_addr = 16'h0500; bus.dm_wdata = 16'h1111;
    n_iss = 0; n_done = 0; pend_chg = 1'b0;
    for (int c = 0; c < 30 && n_done < 4; c++) begin
      if (c > 0) adv();
      if (pend_chg) begin
        bus.dm_addr = bus.dm_addr + 16'h1;
        bus.dm_wdata = bus.dm_wdata + 16'h1111;
        pend_chg = 1'b0;
      end
      mid();
      if (bus.mem_en && n_iss < 4) begin iss_we[n_iss] = bus.mem_we; n_iss++; end
      if (bus.dm_valid || bus.if_valid) n_done++;
      if (bus.dm_valid) pend_chg = 1'b1;
    end
    chk("alt_done", n_done, 4);
    chk("alt_iss0_dm", iss_we[0], 1);
    chk("alt_iss1_if", iss_we[1], 0);
    chk("alt_iss2_dm", iss_we[2], 1);
    chk("alt_iss3_if", iss_we[3], 0);
    adv(); bus.if_req = 1'b0; clr_dm();

`ifdef MEM_ARB_STACK_EN
    adv(); bus.dm_push = 1'b1; bus.dm_wdata = 16'h1234;
    mid();
    chk("push_en", bus.mem_en, 1);
    chk("push_we", bus.mem_we, 1);
    chk("push_addr", bus.mem_addr, 16'hFFFF);
    chk("push_wdata", bus.mem_wdata, 16'h1234);
    chk("push_sp_c0", bus.sp, 16'hFFFF);
    adv(); mid();
    chk("push_sp_c1", bus.sp, 16'hFFFE);
    adv(); mid();
    chk("push_valid", bus.dm_valid, 1);
    adv(); bus.dm_push = 1'b0; bus.dm_pop = 1'b1;
    mid();
    chk("pop_en", bus.mem_en, 1);
    chk("pop_addr", bus.mem_addr, 16'hFFFF);
    chk("pop_we", bus.mem_we, 0);
    adv(); mid();
    chk("pop_sp", bus.sp, 16'hFFFF);
    adv(); mid();
    chk("pop_valid", bus.dm_valid, 1);
    chk("pop_rdata", bus.dm_rdata, 16'h1234);
    adv(); mid();
    chk("pop_wrap_addr", bus.mem_addr, 16'h0000);
    adv(); mid();
    chk("pop_wrap_sp", bus.sp, 16'h0000);
    adv(); mid();
    chk("pop_wrap_rdata", bus.dm_rdata, init_val(16'h0000));
    adv(); bus.dm_pop = 1'b0; bus.dm_push = 1'b1; bus.dm_wdata = 16'h5A5A;
    mid();
    chk("push0_addr", bus.mem_addr, 16'h0000);
    adv(); mid();
    chk("push0_sp_wrap", bus.sp, 16'hFFFF);
    adv(); adv(); bus.dm_push = 1'b0;
    ref_mem[16'hFFFF] = 16'h1234;
    ref_mem[16'h0000] = 16'h5A5A;
    // Reset in the BUSY cycle of a pop, pop held across release.
    adv(); bus.dm_pop = 1'b1;
    mid();
    chk("rmo_c0_addr", bus.mem_addr, 16'h0000);
    adv(); rst = 1'b0;
    mid();
    chk("rmo_rst_valid", bus.dm_valid, 0);
    chk("rmo_rst_sp", bus.sp, 16'hFFFF);
    chk("rmo_rst_en", bus.mem_en, 0);
    adv(); rst = 1'b1;
    mid();
    chk("rmo_rel_valid", bus.dm_valid, 0);
    chk("rmo_reissue_en", bus.mem_en, 1);
    chk("rmo_reissue_addr", bus.mem_addr, 16'h0000);
    adv(); adv(); mid();
    chk("rmo_done_valid", bus.dm_valid, 1);
    chk("rmo_done_rdata", bus.dm_rdata, 16'h5A5A);
    chk("rmo_done_sp", bus.sp, 16'h0000);
    adv(); bus.dm_pop = 1'b0;
`else
    adv(); bus.dm_push = 1'b1; bus.dm_wdata = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin bus.dm_push = 1'b0; bus.dm_pop = 1'b1; end
      mid();
      chk("nostk_en", bus.mem_en, 0);
      chk("nostk_stall", bus.dm_stall, 0);
      chk("nostk_valid", bus.dm_valid, 0);
      chk("nostk_sp", bus.sp, 16'hFFFF);
      adv();
    end
    clr_dm();
    // Reset in the BUSY cycle of a read, read held across release.
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0210;
    mid();
    chk("rmo_c0_addr", bus.mem_addr, 16'h0210);
    adv(); rst = 1'b0;
    mid();
    chk("rmo_rst_valid", bus.dm_valid, 0);
    chk("rmo_rst_en", bus.mem_en, 0);
    adv(); rst = 1'b1;
    mid();
    chk("rmo_rel_valid", bus.dm_valid, 0);
    chk("rmo_reissue_en", bus.mem_en, 1);
    chk("rmo_reissue_addr", bus.mem_addr, 16'h0210);
    adv(); adv(); mid();
    chk("rmo_done_valid", bus.dm_valid, 1);
    chk("rmo_done_rdata", bus.dm_rdata, init_val(16'h0210));
    adv(); clr_dm();
`endif

    // Randomized traffic from a clean reset.
    adv(); rst = 1'b0; bus.if_req = 1'b0; clr_dm();
    adv(); rst = 1'b1;
    free_at = 0; vc = -10; if_vc = -10; dm_vc = -10;
    if_busy = 1'b0; dm_busy = 1'b0; last_dm = 1'b0; own_dm = 1'b0; exp_rdc = 1'b0;
    msp = 16'hFFFF; exp_rd = '0;
    for (int t = 0; t < 400; t++) begin
      adv();
      if (if_busy && if_vc == t - 1) begin if_busy = 1'b0; bus.if_req = 1'b0; end
      if (dm_busy && dm_vc == t - 1) begin dm_busy = 1'b0; clr_dm(); end
      if (!if_busy && $urandom_range(0, 2) == 0) begin
        if_busy = 1'b1; if_vc = -10; bus.if_req = 1'b1;
        bus.if_addr = 16'h0400 | 16'($urandom_range(0, 15));
      end
      if (!dm_busy && $urandom_range(0, 1) == 0) begin
        dm_busy = 1'b1; dm_vc = -10;
`ifdef MEM_ARB_STACK_EN
        flg = 4'($urandom_range(1, 15));
`else
        flg = 4'($urandom_range(1, 3));
`endif
        bus.dm_read = flg[0]; bus.dm_write = flg[1];
        bus.dm_push = flg[2]; bus.dm_pop = flg[3];
        bus.dm_addr = 16'h0400 | 16'($urandom_range(0, 15));
        bus.dm_wdata = 16'($urandom);
      end
      sp_now = msp; exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
      if (t >= free_at && (if_busy || dm_busy)) begin
        exp_en = 1'b1;
        vc = t + MEM_LAT + 1;
        free_at = vc + 1;
        if (dm_busy && !(last_dm && if_busy)) begin
          own_dm = 1'b1; last_dm = 1'b1; dm_vc = vc; exp_rdc = 1'b0;
          if (flg[2]) begin
            exp_we = 1'b1; exp_addr = msp; exp_wd = bus.dm_wdata;
            ref_mem[exp_addr] = exp_wd; msp = msp - 16'h1;
          end else if (flg[3]) begin
            exp_addr = msp + 16'h1; exp_rd = ref_mem[exp_addr]; exp_rdc = 1'b1;
            msp = msp + 16'h1;
          end else if (flg[1]) begin
            exp_we = 1'b1; exp_addr = bus.dm_addr; exp_wd = bus.dm_wdata;
            ref_mem[exp_addr] = exp_wd;
          end else begin
            exp_addr = bus.dm_addr; exp_rd = ref_mem[exp_addr]; exp_rdc = 1'b1;
          end
        end else begin
          own_dm = 1'b0; last_dm = 1'b0; if_vc = vc; exp_rdc = 1'b1;
          exp_addr = bus.if_addr; exp_rd = ref_mem[exp_addr];
        end
      end
      mid();
      chk("rnd_mem_en", bus.mem_en, exp_en);
      if (exp_en) begin
        chk("rnd_mem_addr", bus.mem_addr, exp_addr);
        chk("rnd_mem_we", bus.mem_we, exp_we);
        chk("rnd_mem_wdata", bus.mem_wdata, exp_wd);
      end
      chk("rnd_if_valid", bus.if_valid, (t == vc) && !own_dm);
      chk("rnd_dm_valid", bus.dm_valid, (t == vc) && own_dm);
      if (t == vc && exp_rdc) begin
        if (own_dm) chk("rnd_dm_rdata", bus.dm_rdata, exp_rd);
        else        chk("rnd_if_rdata", bus.if_rdata, exp_rd);
      end
      chk("rnd_if_stall", bus.if_stall, if_busy && !((t == vc) && !own_dm));
      chk("rnd_dm_stall", bus.dm_stall, dm_busy && !((t == vc) && own_dm));
      chk("rnd_sp", bus.sp, sp_now);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
